// File: rtl/t02_arb_pkg.sv
// Shared types and defaults for the RAM port arbiter.
// Index-width helper keeps single-requester builds legal.
package t02_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam int unsigned TIMEOUT_DFLT = 255;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t02_ram_arbiter_if.sv
// Requester and RAM-side signals of the arbiter, grouped as one bus.
// master = requesters plus RAM wrapper; slave = the arbiter itself.
interface t02_ram_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  import t02_arb_pkg::*;

  localparam int unsigned IW = idx_width(NREQ);

  // Requester side
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    done;
  logic               err;
  logic [IW-1:0]      gnt_id;
  logic               busy;

  // RAM side
  logic [AW-1:0]      ramaddr;
  logic [DW-1:0]      ramstore;
  logic               Ren;
  logic               Wen;
  logic [DW-1:0]      ramload;
  logic               busy_o;

  modport master (
    output req, we, addr, wdata, ramload, busy_o,
    input  rdata, done, err, gnt_id, busy, ramaddr, ramstore, Ren, Wen
  );

  modport slave (
    input  req, we, addr, wdata, ramload, busy_o,
    output rdata, done, err, gnt_id, busy, ramaddr, ramstore, Ren, Wen
  );

endinterface

// File: rtl/t02_rr_pick.sv
// Combinational round-robin pick: first requester above the pointer, with wrap.
module t02_rr_pick
  import t02_arb_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic [IW-1:0]   winner,
  output logic            any
);

  logic [IW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = rr;
    // Walk rr+1 .. rr+NREQ so the last-served requester is considered last.
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t02_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NREQ requesters.
// One transaction at a time: grant, issue strobe, wait on busy_o, pulse done.
module t02_ram_arbiter
  import t02_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DFLT
) (
  input logic              clk,
  input logic              rst,
  t02_ram_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_width(NREQ);
  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [IW-1:0]   pick_id;
  logic            pick_any;
  logic            timeout_hit;
  logic [TW-1:0]   timer_inc;

  t02_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (bus.req),
    .rr     (rr_q),
    .winner (pick_id),
    .any    (pick_any)
  );

  assign timeout_hit = (timer_q == TW'(TIMEOUT));
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TW'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    timer_d = timer_q;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_id;
          err_d   = 1'b0;
          timer_d = '0;
          state_d = ISSUE;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_id == IW'(i)) begin
              addr_d  = bus.addr[i*AW +: AW];
              wdata_d = bus.wdata[i*DW +: DW];
              we_d    = bus.we[i];
            end
          end
        end
      end

      ISSUE: begin
        timer_d = timer_inc;
        if (bus.busy_o) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WAIT: begin
        timer_d = timer_inc;
        if (!bus.busy_o) begin
          if (!we_q) begin
            rdata_d = bus.ramload;
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        rr_d    = gnt_q;
        timer_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= IW'(NREQ - 1);
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  // Strobes decode from state only, so a RAM wrapper may answer busy_o combinationally.
  assign bus.Ren      = (state_q == ISSUE) && !we_q;
  assign bus.Wen      = (state_q == ISSUE) && we_q;
  assign bus.done     = (state_q == DONE) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.err      = (state_q == DONE) && err_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.gnt_id   = gnt_q;
  assign bus.rdata    = rdata_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = wdata_q;

endmodule

// File: tb/tb_t02_ram_arbiter.sv
// Directed and randomized checks of the RAM arbiter against a transaction-level model
// and a small behavioural RAM with configurable busy latency.
module tb_t02_ram_arbiter;
  import t02_arb_pkg::*;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  t02_ram_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  t02_ram_arbiter #(
    .NREQ    (NREQ),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // RAM model: busy_o rises with the strobe and stays up ram_lat cycles in total.
  logic          tie_low    = 1'b0;
  logic          force_high = 1'b0;
  int            ram_lat    = 1;
  int            busy_cnt   = 0;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ram_rd;
  int            strobe_cnt = 0;
  logic [AW-1:0] strobe_addr;
  logic          strobe_wr;
  logic [DW-1:0] strobe_data;

  function automatic logic [DW-1:0] init_val(input int unsigned idx);
    return (idx == 0) ? 32'hDEADBEEF : DW'((idx * 32'h9E3779B1) ^ 32'h5A5A0F0F);
  endfunction

  assign bus.busy_o  = !tie_low && (force_high || bus.Ren || bus.Wen || busy_cnt != 0);
  assign bus.ramload = ram_rd;

  always @(posedge clk) begin
    if (rst) begin
      busy_cnt   <= 0;
      strobe_cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
    end else if (!tie_low && (bus.Ren || bus.Wen)) begin
      busy_cnt    <= ram_lat - 1;
      strobe_cnt  <= strobe_cnt + 1;
      strobe_addr <= bus.ramaddr;
      strobe_wr   <= bus.Wen;
      strobe_data <= bus.ramstore;
      if (bus.Wen) mem[bus.ramaddr[7:2]] <= bus.ramstore;
      else         ram_rd <= mem[bus.ramaddr[7:2]];
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Reference memory: contents as the requesters should see them, by full address.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(int'(a[7:2]));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    bus.req    = '0;
    bus.we     = '0;
    bus.addr   = '0;
    bus.wdata  = '0;
    tie_low    = 1'b0;
    force_high = 1'b0;
    ram_lat    = 1;
    tick;
    tick;
    rst = 1'b0;
    ref_mem.delete();
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
    bus.we[i]             = w;
    bus.req[i]            = 1'b1;
  endtask

  task automatic wait_done(input int budget, output logic [NREQ-1:0] d, output int cycles,
                           output int ren_n, output int wen_n);
    d = '0; cycles = 0; ren_n = 0; wen_n = 0;
    while (d == '0 && cycles < budget) begin
      tick;
      cycles++;
      if (bus.Ren) ren_n++;
      if (bus.Wen) wen_n++;
      d = bus.done;
    end
    chk("done_within_budget", 64'(d != '0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] d;
    int              cyc, rn, wn;
    logic [DW-1:0]   last_rd;
    logic [NREQ-1:0] pend;
    logic [AW-1:0]   r_addr [NREQ];
    logic [DW-1:0]   r_data [NREQ];
    logic            r_we   [NREQ];
    int              last, exp_id, n_txn, rcyc;
    logic            mbusy, just_done, found;

    // Reset state
    do_reset;
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_ramaddr", bus.ramaddr, 0);
    chk("rst_ramstore", bus.ramstore, 0);
    chk("rst_ren", bus.Ren, 0);
    chk("rst_wen", bus.Wen, 0);
    chk("rst_gnt", bus.gnt_id, 0);
    chk("rst_busy", bus.busy, 0);

    // Single load, RAM busy for 2 cycles
    ram_lat = 2;
    set_req(0, 1'b0, 32'h100, 32'h0);
    wait_done(20, d, cyc, rn, wn);
    chk("t1_done", d, 3'b001);
    chk("t1_rdata", bus.rdata, 32'hDEADBEEF);
    chk("t1_err", bus.err, 0);
    chk("t1_gnt", bus.gnt_id, 0);
    chk("t1_ren_cycles", rn, 1);
    chk("t1_wen_cycles", wn, 0);
    chk("t1_ramaddr", strobe_addr, 32'h100);
    chk("t1_latency", cyc, ram_lat + 2);
    bus.req = '0;
    tick;
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_idle", bus.busy, 0);

    // All three requesting: strict rotation 0,1,2,0
    do_reset;
    set_req(0, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 32'h14, 32'h0);
    set_req(2, 1'b0, 32'h18, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(20, d, cyc, rn, wn);
      chk("t2_done_order", d, NREQ'(1) << (k % NREQ));
      chk("t2_gnt_order", bus.gnt_id, k % NREQ);
      chk("t2_rdata", bus.rdata, ref_rd(32'h10 + 32'(4 * (k % NREQ))));
      if (k == 3) bus.req = '0;
      tick;
      chk("t2_done_pulse", bus.done, 0);
    end

    // Lone requester held high is re-granted every 4 cycles
    set_req(1, 1'b0, 32'h14, 32'h0);
    wait_done(20, d, cyc, rn, wn);
    wait_done(20, d, cyc, rn, wn);
    chk("t2_regrant_done", d, 3'b010);
    chk("t2_regrant_period", cyc, 4);
    bus.req = '0;
    last_rd = ref_rd(32'h14);
    tick;

    // Store leaves rdata untouched
    set_req(1, 1'b1, 32'h20, 32'h55AA);
    wait_done(20, d, cyc, rn, wn);
    chk("t3_done", d, 3'b010);
    chk("t3_wen_cycles", wn, 1);
    chk("t3_ren_cycles", rn, 0);
    chk("t3_ramstore", strobe_data, 32'h55AA);
    chk("t3_ramaddr", strobe_addr, 32'h20);
    chk("t3_rdata_kept", bus.rdata, last_rd);
    ref_mem[32'h20] = 32'h55AA;
    bus.req = '0;
    tick;
    set_req(0, 1'b0, 32'h20, 32'h0);
    wait_done(20, d, cyc, rn, wn);
    chk("t3_readback", bus.rdata, 32'h55AA);
    bus.req = '0;
    tick;

    // Timeout with busy_o stuck low
    tie_low = 1'b1;
    set_req(2, 1'b0, 32'h30, 32'h0);
    wait_done(600, d, cyc, rn, wn);
    chk("t4_done", d, 3'b100);
    chk("t4_err", bus.err, 1);
    chk("t4_issue_cycles", rn, TIMEOUT + 1);
    bus.req = '0;
    tick;
    chk("t4_idle", bus.busy, 0);
    chk("t4_err_pulse", bus.err, 0);
    tie_low = 1'b0;

    // Inputs change during WAIT: latched address survives, done still pulses
    ram_lat = 5;
    set_req(0, 1'b0, 32'h40, 32'h0);
    tick;
    tick;
    chk("t5_in_wait_ren", bus.Ren, 0);
    chk("t5_in_wait_busy", bus.busy, 1);
    bus.addr[0 +: AW] = 32'h80;
    bus.req[0]        = 1'b0;
    tick;
    chk("t5_ramaddr_held", bus.ramaddr, 32'h40);
    wait_done(20, d, cyc, rn, wn);
    chk("t5_done", d, 3'b001);
    chk("t5_rdata", bus.rdata, ref_rd(32'h40));
    chk("t5_ramaddr_done", bus.ramaddr, 32'h40);
    tick;

    // Reset during WAIT aborts; requester 0 wins first afterwards
    set_req(2, 1'b0, 32'h44, 32'h0);
    tick;
    tick;
    chk("t5b_in_wait", bus.busy, 1);
    rst = 1'b1;
    set_req(0, 1'b0, 32'h48, 32'h0);
    set_req(1, 1'b0, 32'h4C, 32'h0);
    tick;
    chk("t5b_ren", bus.Ren, 0);
    chk("t5b_wen", bus.Wen, 0);
    chk("t5b_done", bus.done, 0);
    chk("t5b_busy", bus.busy, 0);
    rst = 1'b0;
    ram_lat = 1;
    ref_mem.delete();
    tick;
    chk("t5b_gnt", bus.gnt_id, 0);
    chk("t5b_ren_issue", bus.Ren, 1);
    wait_done(20, d, cyc, rn, wn);
    chk("t5b_first_done", d, 3'b001);
    bus.req = '0;
    tick;

    // busy_o already high while idle: ISSUE moves to WAIT on its first cycle
    force_high = 1'b1;
    set_req(1, 1'b0, 32'h24, 32'h0);
    tick;
    chk("t6_issue_ren", bus.Ren, 1);
    tick;
    chk("t6_wait_ren", bus.Ren, 0);
    chk("t6_wait_busy", bus.busy, 1);
    force_high = 1'b0;
    wait_done(20, d, cyc, rn, wn);
    chk("t6_done", d, 3'b010);
    chk("t6_rdata", bus.rdata, ref_rd(32'h24));
    bus.req = '0;
    tick;

    // Randomized traffic against the transaction-level model
    do_reset;
    pend      = '0;
    last      = NREQ - 1;
    mbusy     = 1'b0;
    just_done = 1'b0;
    last_rd   = '0;
    exp_id    = 0;
    n_txn     = 0;
    rcyc      = 0;
    while (n_txn < 150 && rcyc < 20000) begin
      tick;
      rcyc++;
      if (bus.done != '0) begin
        if (!mbusy) begin
          chk("rnd_unexpected_done", bus.done, 0);
        end else begin
          chk("rnd_done", bus.done, NREQ'(1) << exp_id);
          chk("rnd_err", bus.err, 0);
          chk("rnd_strobe_addr", strobe_addr, r_addr[exp_id]);
          chk("rnd_strobe_kind", strobe_wr, r_we[exp_id]);
          if (r_we[exp_id]) begin
            chk("rnd_strobe_data", strobe_data, r_data[exp_id]);
            ref_mem[r_addr[exp_id]] = r_data[exp_id];
          end else begin
            last_rd = ref_rd(r_addr[exp_id]);
          end
          chk("rnd_rdata", bus.rdata, last_rd);
          pend[exp_id]    = 1'b0;
          bus.req[exp_id] = 1'b0;
          last            = exp_id;
          mbusy           = 1'b0;
          just_done       = 1'b1;
          n_txn++;
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(3) == 0) begin
          pend[i]   = 1'b1;
          r_we[i]   = 1'($urandom_range(1));
          r_addr[i] = {24'h0, 6'($urandom_range(63)), 2'b00};
          r_data[i] = $urandom;
          set_req(i, r_we[i], r_addr[i], r_data[i]);
        end
      end
      ram_lat = $urandom_range(4, 1);
      // No grant in the done cycle; the next idle cycle picks above the last served.
      if (just_done) begin
        just_done = 1'b0;
      end else if (!mbusy && pend != '0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          if (!found && pend[(last + k) % NREQ]) begin
            exp_id = (last + k) % NREQ;
            found  = 1'b1;
          end
        end
        mbusy = 1'b1;
      end
    end
    chk("rnd_txn_count", n_txn, 150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
